stage_id: RTL and testbench

- Instruction-decode stage; the consumer end of the fetch interface.
- Latches the fetched instruction and PC+1 into the IF/ID register, reads the 32x32 register file, and resolves branches/jumps.
- Drives the redirect (CS_Branch, PC_MUX_IN) and the stall (CS_PC_Signal_write) back to fetch.
- Detects load-use and branch-operand hazards; registers decoded operands into the ID/EX boundary.

---
 rtl/id_pkg.sv | 22 ++
 rtl/regfile_2r1w.sv | 24 ++
 rtl/stage_id.sv | 103 ++++++++++
 tb/tb_stage_id.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: opcodes, field positions and constants shared by the decode stage.
package id_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int RF_DEPTH = 32;
  localparam int OPC_HI = 31, OPC_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int FN_HI = 5, FN_LO = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int JT_HI = 25;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, two combinational read ports with
// write-first bypass, one synchronous write port, r0 fixed at zero.
module regfile_2r1w
  import id_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);
  logic [31:0] r_mem [RF_DEPTH];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) for (int i = 0; i < RF_DEPTH; i++) r_mem[i] <= '0;
    else if (i_we && i_waddr != '0) r_mem[i_waddr] <= i_wdata;
  always_comb begin
    o_rdata_a = (i_raddr_a == '0) ? '0 : (i_we && i_waddr == i_raddr_a) ? i_wdata : r_mem[i_raddr_a];
    o_rdata_b = (i_raddr_b == '0) ? '0 : (i_we && i_waddr == i_raddr_b) ? i_wdata : r_mem[i_raddr_b];
  end
endmodule

// File: rtl/stage_id.sv
// stage_id: instruction decode with IF/ID latch, branch resolution,
// hazard stall and ID/EX operand registers.
module stage_id
  import id_pkg::*;
(
  input  logic        Clock_in,
  input  logic        Reset_in,
  input  logic [31:0] IF_INS_in,
  input  logic [31:0] IF_PC_NEXT_in,
  output logic        CS_Branch,
  output logic [31:0] PC_MUX_IN,
  output logic        CS_PC_Signal_write,
  input  logic        EX_RegWrite_in,
  input  logic        EX_MemRead_in,
  input  logic [4:0]  EX_Dest_in,
  input  logic        MEM_MemRead_in,
  input  logic [4:0]  MEM_Dest_in,
  input  logic        WB_we_in,
  input  logic [4:0]  WB_addr_in,
  input  logic [31:0] WB_data_in,
  output logic [31:0] ID_RS_DATA,
  output logic [31:0] ID_RT_DATA,
  output logic [31:0] ID_IMM,
  output logic [4:0]  ID_RT,
  output logic [4:0]  ID_RD,
  output logic [5:0]  ID_OPCODE,
  output logic [5:0]  ID_FUNCT,
  output logic        ID_RegWrite,
  output logic        ID_MemRead,
  output logic        ID_MemWrite
);
  logic [31:0] r_ins, r_pc;
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm, w_rs_val, w_rt_val;
  logic w_rtype, w_addi, w_lw, w_sw, w_beq, w_bne, w_j, w_use_rt;
  logic w_ex_hit, w_mem_hit, w_load_use, w_br_stall, w_stall, w_taken;

  regfile_2r1w u_rf (
    .i_clk(Clock_in), .i_rst(Reset_in), .i_we(WB_we_in), .i_waddr(WB_addr_in),
    .i_wdata(WB_data_in), .i_raddr_a(w_rs), .i_raddr_b(w_rt),
    .o_rdata_a(w_rs_val), .o_rdata_b(w_rt_val)
  );

  always_comb begin
    w_op = r_ins[OPC_HI:OPC_LO];
    w_rs = r_ins[RS_HI:RS_LO];
    w_rt = r_ins[RT_HI:RT_LO];
    w_rd = r_ins[RD_HI:RD_LO];
    w_fn = r_ins[FN_HI:FN_LO];
    w_imm = sext16(r_ins[IMM_HI:IMM_LO]);
    w_rtype = w_op == OP_RTYPE;
    w_addi = w_op == OP_ADDI;
    w_lw = w_op == OP_LW;
    w_sw = w_op == OP_SW;
    w_beq = w_op == OP_BEQ;
    w_bne = w_op == OP_BNE;
    w_j = w_op == OP_J;
    w_use_rt = w_rtype | w_beq | w_bne | w_sw;
    w_load_use = EX_MemRead_in && EX_Dest_in != '0 &&
                 (EX_Dest_in == w_rs || (w_use_rt && EX_Dest_in == w_rt));
    // Branches compare in ID, so any in-flight producer of a compared operand must drain first.
    w_ex_hit = EX_RegWrite_in && EX_Dest_in != '0 && (EX_Dest_in == w_rs || EX_Dest_in == w_rt);
    w_mem_hit = MEM_MemRead_in && MEM_Dest_in != '0 && (MEM_Dest_in == w_rs || MEM_Dest_in == w_rt);
    w_br_stall = (w_beq | w_bne) && (w_ex_hit || w_mem_hit);
    w_stall = w_load_use | w_br_stall;
    w_taken = !w_stall && ((w_beq && w_rs_val == w_rt_val) || (w_bne && w_rs_val != w_rt_val) || w_j);
    CS_Branch = w_taken;
    CS_PC_Signal_write = !w_stall;
    PC_MUX_IN = w_j ? {r_pc[31:26], r_ins[JT_HI:0]} : r_pc + w_imm;
  end

  always_ff @(posedge Clock_in or posedge Reset_in)
    if (Reset_in) begin
      r_ins <= NOP_WORD;
      r_pc <= '0;
      ID_RS_DATA <= '0;
      ID_RT_DATA <= '0;
      ID_IMM <= '0;
      ID_RT <= '0;
      ID_RD <= '0;
      ID_OPCODE <= '0;
      ID_FUNCT <= '0;
      ID_RegWrite <= 1'b0;
      ID_MemRead <= 1'b0;
      ID_MemWrite <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_ins <= w_taken ? NOP_WORD : IF_INS_in;
        r_pc <= IF_PC_NEXT_in;
      end
      ID_RS_DATA <= w_stall ? '0 : w_rs_val;
      ID_RT_DATA <= w_stall ? '0 : w_rt_val;
      ID_IMM <= w_stall ? '0 : w_imm;
      ID_RT <= w_stall ? '0 : w_rt;
      ID_RD <= w_stall ? '0 : (w_rtype ? w_rd : w_rt);
      ID_OPCODE <= w_stall ? '0 : w_op;
      ID_FUNCT <= w_stall ? '0 : w_fn;
      ID_RegWrite <= !w_stall && (w_rtype | w_addi | w_lw);
      ID_MemRead <= !w_stall && w_lw;
      ID_MemWrite <= !w_stall && w_sw;
    end
endmodule

// File: tb/tb_stage_id.sv
// tb_stage_id: directed vector table, hand-written reset/stall sequences and
// randomized cycles checked against a behavioural model of the decode stage.
module tb_stage_id;
  logic clk, rst;
  logic [31:0] ins, pcn;
  logic ex_rw, ex_mr, mem_mr, we;
  logic [4:0] ex_d, mem_d, wa;
  logic [31:0] wd;
  logic cs_branch, cs_pcw;
  logic [31:0] pc_mux, id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rt, id_rd;
  logic [5:0] id_op, id_fn;
  logic id_rw, id_mr, id_mw;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] ins, pc;
    logic ex_rw, ex_mr;
    logic [4:0] ex_d;
    logic mem_mr;
    logic [4:0] mem_d;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic chk_c, e_pcw, e_br;
    logic [31:0] e_tgt;
    logic chk_id;
    logic [31:0] e_rs;
    logic [4:0] e_rd;
    logic [31:0] e_imm;
    logic e_rw;
  } vec_t;

  logic [31:0] m_rf [32];
  logic [31:0] m_ins, m_pc;

  stage_id dut (
    .Clock_in(clk), .Reset_in(rst), .IF_INS_in(ins), .IF_PC_NEXT_in(pcn),
    .CS_Branch(cs_branch), .PC_MUX_IN(pc_mux), .CS_PC_Signal_write(cs_pcw),
    .EX_RegWrite_in(ex_rw), .EX_MemRead_in(ex_mr), .EX_Dest_in(ex_d),
    .MEM_MemRead_in(mem_mr), .MEM_Dest_in(mem_d),
    .WB_we_in(we), .WB_addr_in(wa), .WB_data_in(wd),
    .ID_RS_DATA(id_rs_data), .ID_RT_DATA(id_rt_data), .ID_IMM(id_imm),
    .ID_RT(id_rt), .ID_RD(id_rd), .ID_OPCODE(id_op), .ID_FUNCT(id_fn),
    .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_MemWrite(id_mw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ins = '0;
    m_pc = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r, input vec_t v);
    if (r == 5'd0) return 32'd0;
    if (v.we && v.wa == r) return v.wd;
    return m_rf[r];
  endfunction

  task automatic run_cycle(input vec_t v);
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic [31:0] a, b, imm, tgt;
    logic rw, mr, mw, is_br, use_rt, lu, bs, stall, taken;
    ins = v.ins; pcn = v.pc; ex_rw = v.ex_rw; ex_mr = v.ex_mr; ex_d = v.ex_d;
    mem_mr = v.mem_mr; mem_d = v.mem_d; we = v.we; wa = v.wa; wd = v.wd;
    op = m_ins[31:26]; rs = m_ins[25:21]; rt = m_ins[20:16]; rd = m_ins[15:11];
    imm = {{16{m_ins[15]}}, m_ins[15:0]};
    rw = (op == 6'h00) || (op == 6'h08) || (op == 6'h23);
    mr = op == 6'h23;
    mw = op == 6'h2B;
    is_br = (op == 6'h04) || (op == 6'h05);
    use_rt = (op == 6'h00) || is_br || mw;
    a = m_read(rs, v);
    b = m_read(rt, v);
    lu = v.ex_mr && v.ex_d != 0 && (v.ex_d == rs || (use_rt && v.ex_d == rt));
    bs = is_br && ((v.ex_rw && v.ex_d != 0 && (v.ex_d == rs || v.ex_d == rt)) ||
                   (v.mem_mr && v.mem_d != 0 && (v.mem_d == rs || v.mem_d == rt)));
    stall = lu || bs;
    taken = !stall && ((op == 6'h04 && a == b) || (op == 6'h05 && a != b) || op == 6'h02);
    tgt = (op == 6'h02) ? {m_pc[31:26], m_ins[25:0]} : m_pc + imm;
    @(negedge clk);
    chk("pc_write", {31'd0, cs_pcw}, {31'd0, !stall});
    chk("branch", {31'd0, cs_branch}, {31'd0, taken});
    chk("target", pc_mux, tgt);
    if (v.chk_c) begin
      chk("vec_pc_write", {31'd0, cs_pcw}, {31'd0, v.e_pcw});
      chk("vec_branch", {31'd0, cs_branch}, {31'd0, v.e_br});
      chk("vec_target", pc_mux, v.e_tgt);
    end
    @(posedge clk);
    #1;
    chk("rs_data", id_rs_data, stall ? 32'd0 : a);
    chk("rt_data", id_rt_data, stall ? 32'd0 : b);
    chk("imm", id_imm, stall ? 32'd0 : imm);
    chk("rt", {27'd0, id_rt}, {27'd0, stall ? 5'd0 : rt});
    chk("rd", {27'd0, id_rd}, {27'd0, stall ? 5'd0 : (op == 6'h00 ? rd : rt)});
    chk("opcode_funct", {20'd0, id_op, id_fn}, {20'd0, stall ? 12'd0 : {op, m_ins[5:0]}});
    chk("ctrl", {29'd0, id_rw, id_mr, id_mw}, {29'd0, !stall && rw, !stall && mr, !stall && mw});
    if (v.chk_id) begin
      chk("vec_rs_data", id_rs_data, v.e_rs);
      chk("vec_rd", {27'd0, id_rd}, {27'd0, v.e_rd});
      chk("vec_imm", id_imm, v.e_imm);
      chk("vec_regwrite", {31'd0, id_rw}, {31'd0, v.e_rw});
    end
    if (v.we && v.wa != 0) m_rf[v.wa] = v.wd;
    if (!stall) begin
      m_ins = taken ? 32'd0 : v.ins;
      m_pc = v.pc;
    end
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    logic [5:0] op;
    v = '{default: 0};
    case ($urandom_range(0, 7))
      0: op = 6'h00;
      1: op = 6'h08;
      2: op = 6'h23;
      3: op = 6'h2B;
      4: op = 6'h04;
      5: op = 6'h05;
      6: op = 6'h02;
      default: op = 6'($urandom);
    endcase
    v.ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 4)), 11'($urandom)};
    v.pc = $urandom;
    v.ex_rw = 1'($urandom);
    v.ex_mr = $urandom_range(0, 2) == 0;
    v.ex_d = 5'($urandom_range(0, 3));
    v.mem_mr = $urandom_range(0, 2) == 0;
    v.mem_d = 5'($urandom_range(0, 3));
    v.we = 1'($urandom);
    v.wa = 5'($urandom_range(0, 3));
    v.wd = 32'($urandom_range(0, 2));
    return v;
  endfunction

  // Reset asserted between clock edges: everything must clear immediately.
  task automatic reset_mid(input string n);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({n, "_pc_write"}, {31'd0, cs_pcw}, 32'd1);
    chk({n, "_branch"}, {31'd0, cs_branch}, 32'd0);
    chk({n, "_target"}, pc_mux, 32'd0);
    chk({n, "_data"}, id_rs_data | id_rt_data | id_imm, 32'd0);
    chk({n, "_fields"}, {7'd0, id_rw, id_mr, id_mw, id_rd, id_rt, id_op, id_fn}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl [19];
  vec_t q;

  initial begin
    tbl[0]  = '{32'h2001_0005, 32'd1,  1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'd0,      1'b0,32'd0,5'd0,32'd0,1'b0};
    tbl[1]  = '{32'h0,         32'd2,  1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd1,32'd7, 1'b1,1'b1,1'b0,32'd6,      1'b1,32'd0,5'd1,32'd5,1'b1};
    tbl[2]  = '{32'h0,         32'd3,  1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd2,32'd7, 1'b1,1'b1,1'b0,32'd2,      1'b0,32'd0,5'd0,32'd0,1'b0};
    tbl[3]  = '{32'h0060_2020, 32'd4,  1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'd3,      1'b0,32'd0,5'd0,32'd0,1'b0};
    tbl[4]  = '{32'h0,         32'd5,  1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd3,32'hDEAD_BEEF, 1'b1,1'b1,1'b0,32'h2024, 1'b1,32'hDEAD_BEEF,5'd4,32'h2020,1'b1};
    tbl[5]  = '{32'h0045_2020, 32'd6,  1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'd5,      1'b0,32'd0,5'd0,32'd0,1'b0};
    tbl[6]  = '{32'h0,         32'd7,  1'b1,1'b1,5'd2, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b0,1'b0,32'h2026,   1'b1,32'd0,5'd0,32'd0,1'b0};
    tbl[7]  = '{32'h0,         32'd7,  1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'h2026,   1'b1,32'd7,5'd4,32'h2020,1'b1};
    tbl[8]  = '{32'h1022_0004, 32'd10, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'd7,      1'b0,32'd0,5'd0,32'd0,1'b0};
    tbl[9]  = '{32'hFFFF_FFFF, 32'd11, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b1,32'd14,     1'b1,32'd7,5'd2,32'd4,1'b0};
    tbl[10] = '{32'h0,         32'd14, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'd11,     1'b1,32'd0,5'd0,32'd0,1'b1};
    tbl[11] = '{32'h1020_0002, 32'd20, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'd14,     1'b0,32'd0,5'd0,32'd0,1'b0};
    tbl[12] = '{32'h0,         32'd21, 1'b1,1'b1,5'd1, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b0,1'b0,32'd22,     1'b1,32'd0,5'd0,32'd0,1'b0};
    tbl[13] = '{32'h0,         32'd21, 1'b0,1'b0,5'd0, 1'b1,5'd1, 1'b0,5'd0,32'd0, 1'b1,1'b0,1'b0,32'd22,     1'b1,32'd0,5'd0,32'd0,1'b0};
    tbl[14] = '{32'h0,         32'd21, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd1,32'd0, 1'b1,1'b1,1'b1,32'd22,     1'b1,32'd0,5'd0,32'd2,1'b0};
    tbl[15] = '{32'h0800_0100, 32'h0400_0005, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'd21, 1'b0,32'd0,5'd0,32'd0,1'b0};
    tbl[16] = '{32'h0,         32'h0400_0006, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd0,32'h1234, 1'b1,1'b1,1'b1,32'h0400_0100, 1'b1,32'd0,5'd0,32'h100,1'b0};
    tbl[17] = '{32'h2007_0000, 32'h41, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'd0, 1'b1,1'b1,1'b0,32'h0400_0006, 1'b0,32'd0,5'd0,32'd0,1'b0};
    tbl[18] = '{32'h0,         32'h42, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd0,32'hFFFF, 1'b1,1'b1,1'b0,32'h41,  1'b1,32'd0,5'd7,32'd0,1'b1};

    rst = 1'b1;
    ins = '0; pcn = '0; ex_rw = 1'b0; ex_mr = 1'b0; ex_d = '0;
    mem_mr = 1'b0; mem_d = '0; we = 1'b0; wa = '0; wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_reset_pc_write", {31'd0, cs_pcw}, 32'd1);
    chk("post_reset_id", {7'd0, id_rw, id_mr, id_mw, id_rd, id_rt, id_op, id_fn}, 32'd0);

    repeat (40) run_cycle(rnd_vec());
    reset_mid("reset_mid");
    foreach (tbl[i]) run_cycle(tbl[i]);
    repeat (300) run_cycle(rnd_vec());

    q = '{default: 0};
    q.pc = 32'h100;
    run_cycle(q);
    run_cycle(q);
    q.ins = 32'h0045_2020;
    run_cycle(q);
    ins = '0; ex_mr = 1'b1; ex_rw = 1'b1; ex_d = 5'd2;
    @(negedge clk);
    chk("stall_before_reset", {31'd0, cs_pcw}, 32'd0);
    reset_mid("reset_in_stall");
    q = '{default: 0};
    q.ex_mr = 1'b1; q.ex_rw = 1'b1; q.ex_d = 5'd2;
    q.chk_c = 1'b1; q.e_pcw = 1'b1;
    run_cycle(q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
